// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a req/ack memory port and a PC-tagged FIFO.
// Define FETCH_QUEUE_BYPASS_EN to forward an ack straight to the datapath when the FIFO is empty.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] startpc,
    input  logic        redirect,
    input  logic [63:0] redirectpc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [63:0] inst_pc,
    output logic [1:0]  dbg_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [1:0] ST_START   = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_REQ     = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]    state;
    logic [63:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_ins [DEPTH];
    logic [63:0]   q_pc  [DEPTH];
    logic          fifo_valid;
    logic          ack_live;
    logic          push;
    logic          pop;

    assign dbg_state  = state;
    assign fifo_valid = (count != '0);
    // An ack only delivers a usable word in REQ and when no redirect is flushing the stream.
    assign ack_live   = (state == ST_REQ) && mem_ack && !redirect;
    assign pop        = fifo_valid && inst_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass      = ack_live && !fifo_valid;
    assign inst_valid  = fifo_valid || bypass;
    assign instruction = bypass ? mem_rdata : q_ins[rd_ptr];
    assign inst_pc     = bypass ? fetch_pc  : q_pc[rd_ptr];
    assign push        = ack_live && !(bypass && inst_ready);
`else
    assign inst_valid  = fifo_valid;
    assign instruction = q_ins[rd_ptr];
    assign inst_pc     = q_pc[rd_ptr];
    assign push        = ack_live;
`endif

    always_comb begin
        cnt_next = count;
        if (push && !pop) begin
            cnt_next = count + CNT_ONE;
        end else if (pop && !push) begin
            cnt_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state    <= ST_START;
            fetch_pc <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (redirect) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= {redirectpc[63:2], 2'b00};
            // An outstanding request must still see its ack; keep req/addr stable and drop the data later.
            if ((state == ST_REQ || state == ST_DISCARD) && !mem_ack) begin
                state <= ST_DISCARD;
            end else begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
            end
        end else begin
            count <= cnt_next;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case (state)
                ST_START: begin
                    fetch_pc <= {startpc[63:2], 2'b00};
                    state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (count < CNT_MAX) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        fetch_pc <= fetch_pc + 64'd4;
                        if (cnt_next < CNT_MAX) begin
                            mem_addr <= fetch_pc + 64'd4;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_ins[i] <= '0;
                q_pc[i]  <= '0;
            end
        end else if (push) begin
            q_ins[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]  <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (default build) with an expected-instruction scoreboard.
module tb_fetch_queue;
    logic        clk;
    logic        resetl;
    logic [63:0] startpc;
    logic        redirect;
    logic [63:0] redirectpc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [63:0] inst_pc;
    logic [1:0]  dbg_state;

    logic [95:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_pop = -1;
    int last_pop = -1;

    fetch_queue #(.DEPTH(4)) dut (
        .CLK(clk), .resetl(resetl), .startpc(startpc), .redirect(redirect),
        .redirectpc(redirectpc), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [63:0] pc);
        exp_q.push_back({pc, word_of(pc)});
    endtask

    // driver: memory responder with zero wait; answers n requests within budget cycles
    task automatic serve(input int n, input int budget);
        int got = 0;
        int c = 0;
        while (got < n && c < budget) begin
            if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = word_of(mem_addr);
                got++;
            end else begin
                mem_ack = 1'b0;
            end
            tick();
            c++;
        end
        mem_ack = 1'b0;
        check("serve_acks", 64'(got), 64'(n));
    endtask

    task automatic wait_req(input int budget);
        int c = 0;
        while (!mem_req && c < budget) begin
            tick();
            c++;
        end
        check("wait_req", 64'(mem_req), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // monitor / scoreboard: every consumed head is popped against the expected queue
    initial begin
        logic [95:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (resetl && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mon_unexpected: got pc %h want no instruction", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pc", inst_pc, e[95:32]);
                    check("mon_ins", 64'(instruction), 64'(e[31:0]));
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
            end
        end
    end

    initial begin
        resetl = 1'b0; startpc = 64'h1000; redirect = 1'b0; redirectpc = '0;
        mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
        tick(); tick(); tick();

        // reset state
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_ins", 64'(instruction), 64'd0);
        check("rst_pc", inst_pc, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // streaming fetch at one instruction per cycle
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) expect_fetch(64'h1000 + 64'(4 * k));
        first_pop = -1;
        resetl = 1'b1;
        tick();
        check("t1_req_e1", 64'(mem_req), 64'd0);
        check("t1_state_e1", 64'(dbg_state), 64'd1);
        tick();
        check("t1_req_e2", 64'(mem_req), 64'd1);
        check("t1_addr_e2", mem_addr, 64'h1000);
        serve(8, 40);
        wait_drain(20);
        check("t1_span", 64'(last_pop - first_pop), 64'd7);
        check("t1_empty", 64'(inst_valid), 64'd0);
        check("t1_outstanding", 64'(mem_req), 64'd1);

        // asynchronous reset mid-request, then a late ack during START
        inst_ready = 1'b0;
        resetl = 1'b0;
        #1;
        check("rst_mid_req", 64'(mem_req), 64'd0);
        check("rst_mid_valid", 64'(inst_valid), 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        startpc = 64'h3006;
        tick(); tick();
        resetl = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("late_ack_valid", 64'(inst_valid), 64'd0);
        check("late_ack_req", 64'(mem_req), 64'd0);
        tick();
        check("restart_req", 64'(mem_req), 64'd1);
        check("restart_addr", mem_addr, 64'h3004);

        // fill with datapath stalled, then resume
        for (int k = 0; k < 6; k++) expect_fetch(64'h3004 + 64'(4 * k));
        serve(4, 20);
        check("t2_full_req", 64'(mem_req), 64'd0);
        check("t2_full_state", 64'(dbg_state), 64'd1);
        check("t2_head_pc", inst_pc, 64'h3004);
        check("t2_head_ins", 64'(instruction), 64'(word_of(64'h3004)));
        tick(); tick();
        check("t2_hold_req", 64'(mem_req), 64'd0);
        inst_ready = 1'b1;
        wait_req(10);
        check("t2_resume_addr", mem_addr, 64'h3014);
        serve(2, 20);
        wait_drain(20);

        // ack delayed three cycles
        expect_fetch(64'h301C);
        for (int k = 0; k < 3; k++) begin
            check("t3_req_stable", 64'(mem_req), 64'd1);
            check("t3_addr_stable", mem_addr, 64'h301C);
            check("t3_no_push", 64'(inst_valid), 64'd0);
            tick();
        end
        mem_ack = 1'b1;
        mem_rdata = word_of(64'h301C);
        tick();
        mem_ack = 1'b0;
        check("t3_valid_after_ack", 64'(inst_valid), 64'd1);
        check("t3_next_addr", mem_addr, 64'h3020);
        wait_drain(10);

        // redirect while a request is outstanding
        inst_ready = 1'b0;
        serve(2, 10);
        check("t4_pre_valid", 64'(inst_valid), 64'd1);
        redirect = 1'b1;
        redirectpc = 64'h2002;
        tick();
        redirect = 1'b0;
        check("t4_flush_valid", 64'(inst_valid), 64'd0);
        check("t4_hold_req", 64'(mem_req), 64'd1);
        check("t4_hold_addr", mem_addr, 64'h3028);
        check("t4_state", 64'(dbg_state), 64'd3);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("t4_stale_dropped", 64'(inst_valid), 64'd0);
        check("t4_req_low", 64'(mem_req), 64'd0);
        tick();
        check("t4_new_req", 64'(mem_req), 64'd1);
        check("t4_new_addr", mem_addr, 64'h2000);

        // redirect and ack in the same cycle
        redirect = 1'b1;
        redirectpc = 64'h4001;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        redirect = 1'b0;
        mem_ack = 1'b0;
        check("t5_no_push", 64'(inst_valid), 64'd0);
        check("t5_req_low", 64'(mem_req), 64'd0);
        check("t5_state", 64'(dbg_state), 64'd1);
        tick();
        check("t5_new_req", 64'(mem_req), 64'd1);
        check("t5_new_addr", mem_addr, 64'h4000);
        inst_ready = 1'b1;
        expect_fetch(64'h4000);
        expect_fetch(64'h4004);
        serve(2, 10);
        wait_drain(10);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the single-cycle datapath's instruction port. It runs a req/ack handshake to a variable-latency instruction memory, buffers fetched words with their PCs in a small FIFO, and presents them to the datapath through a valid/ready interface. A redirect input, driven by the datapath's next-PC logic on taken branches, flushes the FIFO and restarts fetch.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CLK  in  1  clock; all state updates on rising edge
- resetl  in  1  asynchronous, active-low reset
- startpc  in  64  fetch start address, sampled in START state
- redirect  in  1  flush and restart fetch at redirectpc
- redirectpc  in  64  new fetch address
- mem_req  out  1  registered; memory request
- mem_addr  out  64  registered; request address, bits [1:0] always 0
- mem_ack  in  1  memory response strobe; mem_rdata valid same cycle
- mem_rdata  in  32  instruction word
- inst_valid  out  1  head entry valid
- inst_ready  in  1  datapath consumes head this cycle
- instruction  out  32  head instruction word
- inst_pc  out  64  PC of head instruction

## Operation
- Reset values: state=START, fetch_pc=0, count=0, rd/wr pointers=0, mem_req=0, mem_addr=0, inst_valid=0, instruction=0, inst_pc=0.
- States: START, IDLE, REQ, DISCARD.
- START: fetch_pc←{startpc[63:2],2'b00}; →IDLE. A redirect in START overrides startpc.
- IDLE: if count<DEPTH, assert mem_req with mem_addr=fetch_pc, →REQ; else stay.
- REQ: mem_req and mem_addr held stable until mem_ack. On ack: push {fetch_pc, mem_rdata}, fetch_pc←fetch_pc+4 (mod 2^64). If post-push/pop count<DEPTH, stay REQ with mem_addr=fetch_pc+4 (back-to-back); else drop mem_req, →IDLE.
- DISCARD: mem_req held until mem_ack; returned data dropped; →IDLE.
- Redirect (highest priority): count←0, pointers←0, fetch_pc←{redirectpc[63:2],2'b00}. In REQ without ack that cycle →DISCARD. In REQ with ack the same cycle, data is dropped →IDLE. Otherwise →IDLE. A pop in the redirect cycle is counted as consumed; nothing is pushed.
- Pop: inst_valid & inst_ready advances the read pointer. Push and pop in the same cycle leave count unchanged. Full plus pop plus ack is legal.
- A request issues only when count<DEPTH, so a push never overflows. Pop when empty is ignored.
- inst_valid = (count≠0). instruction/inst_pc = head entry.

## Timing
- mem_req never drops before the ack is sampled; mem_addr does not change while mem_req=1 and no ack has been sampled.
- Reset deassert → START (1 cycle) → mem_req high on the 2nd rising edge after deassert.
- Ack at edge N → inst_valid=1 after edge N (visible cycle N+1).
- Redirect at edge N → inst_valid=0 in cycle N+1; the first request to redirectpc issues at edge N+1 from IDLE, or after the outstanding ack from DISCARD.
- Zero-wait memory (ack every cycle while req) with inst_ready=1 sustains one instruction per cycle.
- Reset asserted mid-transaction: all state returns to reset values immediately. A late ack arriving after reset is ignored.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0, state=REQ and mem_ack=1, mem_rdata and fetch_pc drive instruction/inst_pc combinationally with inst_valid=1 in the same cycle. If inst_ready=1, the word is not pushed. Redirect still suppresses the bypass.
- Undefined: all outputs are registered; minimum ack-to-valid latency is 1 cycle.

## Test plan
- Reset release, startpc=0x1000, ack on every request, inst_ready=1 → instructions appear with inst_pc 0x1000, 0x1004, 0x1008…, one per cycle after the initial latency.
- inst_ready=0, DEPTH=4 → exactly 4 pushes, then mem_req=0 with state IDLE. Raise inst_ready → fetch resumes at 0x1010.
- Ack delayed 3 cycles → mem_req and mem_addr stay stable for all 3 cycles; no push before the ack.
- Redirect to 0x2002 while a request is outstanding → FIFO empties the next cycle; the stale ack data is dropped; the next mem_addr is 0x2000.
- Redirect and ack in the same cycle → no push; the next request goes to redirectpc.
- resetl low mid-REQ → mem_req=0 and inst_valid=0 immediately. After release, fetch restarts at startpc.
